led_chain_arbiter: RTL

Sequencer and arbiter for the single 16-bit serial LED chain driven by the LED parallel-to-serial shifter. It accepts display updates from two independent requesters, such as the GPIO output register and a debug/status source, and grants them round-robin. For each granted update it issues one start pulse and a stable parallel word to the shifter, then waits for the shifter's completion pulse. It also re-sends the displayed word periodically and recovers from a shifter that never completes.

---
 rtl/led_chain_arbiter.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/led_chain_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : led_chain_arbiter
// Purpose  : Round-robin sequencer feeding one serial LED chain shifter, with
//            periodic re-send (optional, LED_CHAIN_REFRESH_EN) and done timeout.
// Revision : 1.0  initial release
// ============================================================================
module led_chain_arbiter #(
  parameter int DATA_BITS      = 16,
  parameter int REFRESH_CYCLES = 1000000,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0,
  input  logic [DATA_BITS-1:0] req0_data,
  output logic                 grant0,
  input  logic                 req1,
  input  logic [DATA_BITS-1:0] req1_data,
  output logic                 grant1,
  output logic                 p2s_start,
  output logic [DATA_BITS-1:0] p2s_data,
  input  logic                 p2s_done,
  output logic [DATA_BITS-1:0] shown,
  output logic                 busy,
  output logic                 timeout_err
);

  localparam int c_to_w = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [c_to_w-1:0] c_to_last = c_to_w'(TIMEOUT_CYCLES - 1);
  localparam logic [c_to_w-1:0] c_to_one  = c_to_w'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic                  r_last_grant;
  logic [c_to_w-1:0]     r_to_cnt;
  logic                  r_start;
  logic                  r_grant0;
  logic                  r_grant1;
  logic [DATA_BITS-1:0]  r_data;
  logic [DATA_BITS-1:0]  r_shown;
  logic                  r_err;

  logic                  w_refresh_due;
  logic                  w_pick1;
  logic                  w_take_req;
  logic                  w_take_refresh;
  logic                  w_done_ok;
  logic                  w_timeout;

  // r_last_grant holds the index of the requester granted most recently
  assign w_pick1 = req1 & (~req0 | ~r_last_grant);

  always_comb begin
    w_state_next   = r_state;
    w_take_req     = 1'b0;
    w_take_refresh = 1'b0;
    w_done_ok      = 1'b0;
    w_timeout      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (req0 | req1) begin
          w_take_req   = 1'b1;
          w_state_next = ST_LOAD;
        end else if (w_refresh_due) begin
          w_take_refresh = 1'b1;
          w_state_next   = ST_LOAD;
        end
      end
      ST_LOAD: w_state_next = ST_WAIT;
      ST_WAIT: begin
        // a completion on the terminal count still counts as a completion
        if (p2s_done) begin
          w_done_ok    = 1'b1;
          w_state_next = ST_IDLE;
        end else if (r_to_cnt == c_to_last) begin
          w_timeout    = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_last_grant <= 1'b1;
      r_to_cnt     <= '0;
      r_start      <= 1'b0;
      r_grant0     <= 1'b0;
      r_grant1     <= 1'b0;
      r_data       <= '0;
      r_shown      <= '0;
      r_err        <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_start  <= w_take_req | w_take_refresh;
      r_grant0 <= w_take_req & ~w_pick1;
      r_grant1 <= w_take_req & w_pick1;
      if (w_take_req) begin
        r_data       <= w_pick1 ? req1_data : req0_data;
        r_last_grant <= w_pick1;
      end else if (w_take_refresh) begin
        r_data <= r_shown;
      end
      if (r_state == ST_LOAD) begin
        r_to_cnt <= '0;
      end else if (r_state == ST_WAIT) begin
        r_to_cnt <= r_to_cnt + c_to_one;
      end
      if (w_done_ok) begin
        r_shown <= r_data;
      end
      if (w_timeout) begin
        r_err <= 1'b1;
      end
    end
  end

`ifdef LED_CHAIN_REFRESH_EN
  localparam int c_ref_w = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [c_ref_w-1:0] c_ref_last = c_ref_w'(REFRESH_CYCLES - 1);
  localparam logic [c_ref_w-1:0] c_ref_one  = c_ref_w'(1);

  logic [c_ref_w-1:0] r_ref_cnt;

  // saturating at the last value doubles as the refresh-due flag
  assign w_refresh_due = (r_ref_cnt == c_ref_last);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ref_cnt <= '0;
    end else if (w_done_ok) begin
      r_ref_cnt <= '0;
    end else if (!w_refresh_due) begin
      r_ref_cnt <= r_ref_cnt + c_ref_one;
    end
  end
`else
  assign w_refresh_due = 1'b0;
`endif

  assign grant0      = r_grant0;
  assign grant1      = r_grant1;
  assign p2s_start   = r_start;
  assign p2s_data    = r_data;
  assign shown       = r_shown;
  assign busy        = (r_state != ST_IDLE);
  assign timeout_err = r_err;

endmodule
`default_nettype wire
